datomic_responder: RTL and testbench

Memory-side responder for the data request interface that the instruction decoder drives: it services the datapath's `dmemREN`/`dmemWEN`/`datomic` requests against the single-word RAM port, stalls the pipeline with `dhit`, and implements LL/SC via a one-entry link register. It sits between the datapath and the RAM arbiter, in place of the pass-through data path.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/datomic_responder_if.sv | 42 ++++
 rtl/link_register.sv | 38 +++
 rtl/datomic_responder.sv | 109 ++++++++++
 tb/tb_datomic_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-side types for the data responder
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Prefixed so the literals do not collide with ramstate_t::ACCESS.
    typedef enum logic [1:0] {
        DR_IDLE,
        DR_ACCESS,
        DR_SCFAIL,
        DR_DONE
    } dresp_state_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] addr;
    } link_t;

    function automatic logic [29:0] word_addr(input word_t a);
        return a[31:2];
    endfunction
endpackage

// File: rtl/datomic_responder_if.sv
// rtl/datomic_responder_if.sv - datapath request and RAM port bundle; LINK_SNOOP_EN adds snoop signals
interface datomic_responder_if;
    import cpu_types_pkg::*;

    logic      dmemREN;
    logic      dmemWEN;
    logic      datomic;
    word_t     dmemaddr;
    word_t     dmemstore;
    word_t     dmemload;
    logic      dhit;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
`ifdef LINK_SNOOP_EN
    logic      snoopvalid;
    word_t     snoopaddr;

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, ramload, ramstate,
               snoopvalid, snoopaddr,
        input  dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, ramload, ramstate,
               snoopvalid, snoopaddr,
        output dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );
`else
    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, ramload, ramstate,
        input  dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, ramload, ramstate,
        output dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );
`endif
endinterface

// File: rtl/link_register.sv
// rtl/link_register.sv - one-entry LL/SC link with set, clear and snoop-clear
module link_register
    import cpu_types_pkg::*;
#(
    parameter int LINK_ADDR_LSB = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t addr_i,
    input  logic  set_i,
    input  logic  clr_i,
    input  logic  snoop_valid_i,
    input  word_t snoop_addr_i,
    output logic  match_o,
    output logic  snoop_hit_o
);
    // Word bits below LINK_ADDR_LSB are masked out of every compare.
    localparam logic [29:0] CMP_MASK = {30{1'b1}} << (LINK_ADDR_LSB - 2);

    link_t link_q;

    assign match_o     = link_q.valid &&
                         (((word_addr(addr_i) ^ link_q.addr) & CMP_MASK) == '0);
    assign snoop_hit_o = snoop_valid_i && link_q.valid &&
                         (((word_addr(snoop_addr_i) ^ link_q.addr) & CMP_MASK) == '0);

    // A completing LL takes precedence over a same-cycle snoop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_q <= '0;
        end else if (set_i) begin
            link_q.valid <= 1'b1;
            link_q.addr  <= word_addr(addr_i);
        end else if (clr_i || snoop_hit_o) begin
            link_q.valid <= 1'b0;
        end
    end
endmodule

// File: rtl/datomic_responder.sv
// rtl/datomic_responder.sv - data request responder with LL/SC link; LINK_SNOOP_EN enables remote link snooping
module datomic_responder
    import cpu_types_pkg::*;
#(
    parameter int LINK_ADDR_LSB = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    datomic_responder_if.slave  bus
);
    dresp_state_t state_q;
    logic         atomic_q;
    logic         ramren_q;
    logic         ramwen_q;
    word_t        ramaddr_q;
    word_t        ramstore_q;

    logic  ram_done, link_match, snoop_hit, link_set, link_clr, sc_ok;
    logic  dhit_c, snoop_valid;
    word_t load_c, link_addr, snoop_addr;

`ifdef LINK_SNOOP_EN
    assign snoop_valid = bus.snoopvalid;
    assign snoop_addr  = bus.snoopaddr;
`else
    assign snoop_valid = 1'b0;
    assign snoop_addr  = '0;
`endif

    // The link compares against the incoming address while idle, else the captured one.
    assign link_addr = (state_q == DR_IDLE) ? bus.dmemaddr : ramaddr_q;
    assign ram_done  = (state_q == DR_ACCESS) && (bus.ramstate == ACCESS);
    assign sc_ok     = link_match && !snoop_hit;
    assign link_set  = ram_done && ramren_q && atomic_q;
    assign link_clr  = ram_done && ramwen_q && (atomic_q || link_match);

    link_register #(.LINK_ADDR_LSB(LINK_ADDR_LSB)) u_link (
        .CLK          (CLK),
        .nRST         (nRST),
        .addr_i       (link_addr),
        .set_i        (link_set),
        .clr_i        (link_clr),
        .snoop_valid_i(snoop_valid),
        .snoop_addr_i (snoop_addr),
        .match_o      (link_match),
        .snoop_hit_o  (snoop_hit)
    );

    always_comb begin
        dhit_c = 1'b0;
        load_c = '0;
        if (state_q == DR_SCFAIL) begin
            dhit_c = 1'b1;
        end else if (ram_done) begin
            dhit_c = 1'b1;
            if (ramren_q)      load_c = bus.ramload;
            else if (atomic_q) load_c = 32'd1;
        end
    end

    assign bus.dhit     = dhit_c;
    assign bus.dmemload = load_c;
    assign bus.ramREN   = ramren_q;
    assign bus.ramWEN   = ramwen_q;
    assign bus.ramaddr  = ramaddr_q;
    assign bus.ramstore = ramstore_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= DR_IDLE;
            atomic_q   <= 1'b0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            case (state_q)
                DR_IDLE: begin
                    if (bus.dmemWEN) begin
                        atomic_q <= bus.datomic;
                        if (bus.datomic && !sc_ok) begin
                            state_q <= DR_SCFAIL;
                        end else begin
                            state_q    <= DR_ACCESS;
                            ramwen_q   <= 1'b1;
                            ramaddr_q  <= bus.dmemaddr;
                            ramstore_q <= bus.dmemstore;
                        end
                    end else if (bus.dmemREN) begin
                        atomic_q  <= bus.datomic;
                        state_q   <= DR_ACCESS;
                        ramren_q  <= 1'b1;
                        ramaddr_q <= bus.dmemaddr;
                    end
                end
                // ERROR, BUSY and FREE all keep the request driven unchanged.
                DR_ACCESS: begin
                    if (bus.ramstate == ACCESS) begin
                        state_q  <= DR_DONE;
                        ramren_q <= 1'b0;
                        ramwen_q <= 1'b0;
                    end
                end
                DR_SCFAIL: state_q <= DR_DONE;
                default:   state_q <= DR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datomic_responder.sv
// tb/tb_datomic_responder.sv - vector table, corner sequences and random LL/SC traffic for datomic_responder
module tb_datomic_responder;
    import cpu_types_pkg::*;

    localparam int OP_LW = 0, OP_LL = 1, OP_SW = 2, OP_SC = 3;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        int          nwait;
        bit          err;
        logic [31:0] rdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    logic CLK;
    logic nRST;
    datomic_responder_if bus ();

    datomic_responder #(.LINK_ADDR_LSB(2)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference link: valid flag plus word address.
    bit          m_valid = 1'b0;
    logic [29:0] m_word  = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input int op, input word_t addr, input word_t data, input int nwait,
                       input bit err, input word_t rdata, output word_t got);
        bit wr, at, fail;
        wr   = (op == OP_SW) || (op == OP_SC);
        at   = (op == OP_LL) || (op == OP_SC);
        fail = (op == OP_SC) && !(m_valid && m_word == addr[31:2]);
        got  = '0;
        @(negedge CLK);
        bus.dmemREN   = !wr;
        bus.dmemWEN   = wr;
        bus.datomic   = at;
        bus.dmemaddr  = addr;
        bus.dmemstore = data;
        bus.ramstate  = FREE;
        #1;
        chk("idle_dhit", 32'(bus.dhit), 32'd0);
        chk("idle_ramreq", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        if (fail) begin
            @(negedge CLK);
            bus.ramstate = ACCESS;
            #1;
            got = bus.dmemload;
            chk("scfail_dhit", 32'(bus.dhit), 32'd1);
            chk("scfail_ramwen", 32'(bus.ramWEN), 32'd0);
            chk("scfail_load", got, 32'd0);
        end else begin
            for (int w = 0; w <= nwait; w++) begin
                @(negedge CLK);
                if (w == nwait) begin
                    bus.ramstate = ACCESS;
                    bus.ramload  = rdata;
                end else begin
                    bus.ramstate = err ? ERROR : (((w % 2) != 0) ? FREE : BUSY);
                    bus.ramload  = $urandom;
                end
                #1;
                chk("ram_req", 32'({bus.ramREN, bus.ramWEN}), 32'({!wr, wr}));
                chk("ramaddr", bus.ramaddr, addr);
                if (wr) chk("ramstore", bus.ramstore, data);
                chk("dhit", 32'(bus.dhit), 32'(w == nwait));
                if (w == nwait) begin
                    got = bus.dmemload;
                    if (op == OP_SC)  chk("sc_ok_load", got, 32'd1);
                    else if (!wr)     chk("read_load", got, rdata);
                end
            end
        end
        if (op == OP_LL) begin
            m_valid = 1'b1;
            m_word  = addr[31:2];
        end else if (op == OP_SC && !fail) begin
            m_valid = 1'b0;
        end else if (op == OP_SW && m_valid && m_word == addr[31:2]) begin
            m_valid = 1'b0;
        end
        // Request still held during the bubble: it must not be re-issued.
        @(negedge CLK);
        bus.ramstate = FREE;
        #1;
        chk("bubble", 32'({bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tv[18];
        word_t got;

        tv[0]  = '{OP_LW, 32'h100, 32'h0,  2, 1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tv[1]  = '{OP_SC, 32'h200, 32'h7,  0, 1'b0, 32'h0,        1'b1, 32'h0};
        tv[2]  = '{OP_LL, 32'h200, 32'h0,  1, 1'b0, 32'h1234,     1'b1, 32'h1234};
        tv[3]  = '{OP_SC, 32'h200, 32'h5,  0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h1};
        tv[4]  = '{OP_SC, 32'h200, 32'h5,  0, 1'b0, 32'h0,        1'b1, 32'h0};
        tv[5]  = '{OP_LL, 32'h200, 32'h0,  0, 1'b0, 32'hA5,       1'b1, 32'hA5};
        tv[6]  = '{OP_SW, 32'h203, 32'h9,  1, 1'b0, 32'h0,        1'b0, 32'h0};
        tv[7]  = '{OP_SC, 32'h200, 32'h3,  0, 1'b0, 32'h0,        1'b1, 32'h0};
        tv[8]  = '{OP_LL, 32'h200, 32'h0,  0, 1'b0, 32'h11,       1'b1, 32'h11};
        tv[9]  = '{OP_SW, 32'h204, 32'h9,  0, 1'b0, 32'h0,        1'b0, 32'h0};
        tv[10] = '{OP_SC, 32'h200, 32'h6,  2, 1'b0, 32'h0,        1'b1, 32'h1};
        tv[11] = '{OP_LL, 32'h300, 32'h0,  0, 1'b0, 32'h22,       1'b1, 32'h22};
        tv[12] = '{OP_SW, 32'h100, 32'h55, 4, 1'b1, 32'h0,        1'b0, 32'h0};
        tv[13] = '{OP_SC, 32'h302, 32'h8,  0, 1'b0, 32'h0,        1'b1, 32'h1};
        tv[14] = '{OP_LL, 32'h200, 32'h0,  0, 1'b0, 32'h1,        1'b1, 32'h1};
        tv[15] = '{OP_LL, 32'h400, 32'h0,  1, 1'b0, 32'h2,        1'b1, 32'h2};
        tv[16] = '{OP_SC, 32'h200, 32'h4,  0, 1'b0, 32'h0,        1'b1, 32'h0};
        tv[17] = '{OP_SC, 32'h400, 32'h4,  1, 1'b1, 32'h0,        1'b1, 32'h1};

        nRST          = 1'b0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.datomic   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
`ifdef LINK_SNOOP_EN
        bus.snoopvalid = 1'b0;
        bus.snoopaddr  = '0;
`endif
        #1;
        chk("rst_outputs", 32'({bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
        chk("rst_ramaddr", bus.ramaddr | bus.ramstore | bus.dmemload, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            txn(tv[i].op, tv[i].addr, tv[i].data, tv[i].nwait, tv[i].err, tv[i].rdata, got);
            if (tv[i].chk) chk($sformatf("vec%0d_load", i), got, tv[i].exp);
        end

        // Reset while an LL is mid-access abandons it and drops the link.
        txn(OP_LL, 32'h200, 32'h0, 0, 1'b0, 32'h9, got);
        @(negedge CLK);
        bus.dmemREN  = 1'b1;
        bus.datomic  = 1'b1;
        bus.dmemaddr = 32'h200;
        @(negedge CLK);
        bus.ramstate = BUSY;
        #1;
        chk("pre_rst_ramren", 32'(bus.ramREN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_req", 32'({bus.dhit, bus.ramREN, bus.ramWEN}), 32'd0);
        chk("midrst_ramaddr", bus.ramaddr, 32'd0);
        chk("midrst_load", bus.dmemload, 32'd0);
        m_valid = 1'b0;
        bus.dmemREN = 1'b0;
        bus.datomic = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        txn(OP_SC, 32'h200, 32'h1, 0, 1'b0, 32'h0, got);
        chk("sc_after_rst", got, 32'd0);

        // Both REN and WEN: the write wins.
        @(negedge CLK);
        bus.dmemREN   = 1'b1;
        bus.dmemWEN   = 1'b1;
        bus.dmemaddr  = 32'h500;
        bus.dmemstore = 32'h77;
        @(negedge CLK);
        bus.ramstate = ACCESS;
        #1;
        chk("prio_req", 32'({bus.ramREN, bus.ramWEN}), 32'b01);
        chk("prio_store", bus.ramstore, 32'h77);
        chk("prio_dhit", 32'(bus.dhit), 32'd1);
        @(negedge CLK);
        bus.ramstate = FREE;
        bus.dmemREN  = 1'b0;
        bus.dmemWEN  = 1'b0;
        if (m_valid && m_word == 30'h140) m_valid = 1'b0;

`ifdef LINK_SNOOP_EN
        txn(OP_LL, 32'h200, 32'h0, 0, 1'b0, 32'h3, got);
        @(negedge CLK);
        bus.snoopvalid = 1'b1;
        bus.snoopaddr  = 32'h201;
        @(negedge CLK);
        bus.snoopvalid = 1'b0;
        m_valid = 1'b0;
        txn(OP_SC, 32'h200, 32'h1, 0, 1'b0, 32'h0, got);
        chk("snoop_sc", got, 32'd0);

        txn(OP_LL, 32'h200, 32'h0, 0, 1'b0, 32'h3, got);
        bus.snoopvalid = 1'b1;
        bus.snoopaddr  = 32'h200;
        m_valid = 1'b0;
        txn(OP_SC, 32'h200, 32'h1, 0, 1'b0, 32'h0, got);
        chk("snoop_same_cycle_sc", got, 32'd0);

        fork
            begin
                repeat (2) @(negedge CLK);
                #7;
                bus.snoopvalid = 1'b0;
            end
        join_none
        txn(OP_LL, 32'h200, 32'h0, 0, 1'b0, 32'h4, got);
        txn(OP_SC, 32'h200, 32'h1, 0, 1'b0, 32'h0, got);
        chk("ll_beats_snoop", got, 32'd1);
`endif

        for (int i = 0; i < 150; i++) begin
            int    op;
            word_t addr;
            op   = int'($urandom_range(0, 3));
            addr = 32'h200 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            txn(op, addr, $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                $urandom, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
